// File: rtl/hex_disp_pkg.sv
// Shared definitions for the hex display arbiter: state encoding, digit-word
// geometry and the {enable, nibble} packing helper.
package hex_disp_pkg;

   localparam int unsigned DIGITS  = 8;
   localparam int unsigned NIB_W   = 4;
   localparam int unsigned EN_BIT  = 4;
   localparam int unsigned DIGIT_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_e;

   function automatic logic [DIGIT_W-1:0] pack_digit(input logic en,
                                                     input logic [NIB_W-1:0] nib);
      return {en, nib};
   endfunction

endpackage

// File: rtl/hex_lz_blank.sv
// Leading-zero blanking mask: a digit is lit when blanking is off, when it is
// digit 0, or when it or any more significant nibble is nonzero.
module hex_lz_blank
   import hex_disp_pkg::*;
(
   input  logic [31:0] value,
   input  logic        blank,
   output logic [7:0]  en_mask
);

   always_comb begin
      en_mask = '0;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         en_mask[k] = !blank || (k == 0) || ((value >> (k * NIB_W)) != '0);
      end
   end

endmodule

// File: rtl/hex_display_arbiter.sv
// Round-robin owner of the 8-digit hex display with a minimum hold time;
// registers the owner's value as eight {enable, nibble} digit words.
module hex_display_arbiter
   import hex_disp_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 1000,
   parameter int unsigned CNT_W       = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [1:0]  req_i,
   input  logic [31:0] data0_i,
   input  logic [31:0] data1_i,
   input  logic        blank_lz_i,
   output logic [1:0]  grant_o,
   output logic [4:0]  hex0_o,
   output logic [4:0]  hex1_o,
   output logic [4:0]  hex2_o,
   output logic [4:0]  hex3_o,
   output logic [4:0]  hex4_o,
   output logic [4:0]  hex5_o,
   output logic [4:0]  hex6_o,
   output logic [4:0]  hex7_o
);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_OWN0 = OWN0;
   localparam logic [1:0] ST_OWN1 = OWN1;

   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

   logic [1:0]         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ptr_q, ptr_d;
   logic [1:0]         grant_q;
   logic               win;
   logic               owner;
   logic               capture;
   logic [31:0]        sel_data;
   logic [7:0]         en_mask;
   logic [DIGIT_W-1:0] digit_q [DIGITS];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      win     = 1'b0;
      owner   = (state_q == ST_OWN1);
      case (state_q)
         ST_IDLE: begin
            if (req_i != 2'b00) begin
               win     = req_i[ptr_q] ? ptr_q : !ptr_q;
               state_d = win ? ST_OWN1 : ST_OWN0;
               cnt_d   = HOLD_LOAD;
               ptr_d   = !win;
            end
         end
         ST_OWN0, ST_OWN1: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (req_i[!owner]) begin
               state_d = owner ? ST_OWN0 : ST_OWN1;
               cnt_d   = HOLD_LOAD;
               ptr_d   = owner;
            end else if (!req_i[owner]) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign sel_data = (state_q == ST_OWN1) ? data1_i : data0_i;
   assign capture  = ((state_q == ST_OWN0) && req_i[0]) ||
                     ((state_q == ST_OWN1) && req_i[1]);

   hex_lz_blank u_blank (
      .value   (sel_data),
      .blank   (blank_lz_i),
      .en_mask (en_mask)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ptr_q   <= 1'b0;
         grant_q <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         grant_q <= {state_d == ST_OWN1, state_d == ST_OWN0};
      end
   end

   // Enables drop on the edge that enters IDLE; nibble fields keep their value.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned k = 0; k < DIGITS; k++) digit_q[k] <= '0;
      end else if (state_d == ST_IDLE) begin
         for (int unsigned k = 0; k < DIGITS; k++) digit_q[k][EN_BIT] <= 1'b0;
      end else if (capture) begin
         for (int unsigned k = 0; k < DIGITS; k++)
            digit_q[k] <= pack_digit(en_mask[k], sel_data[k*NIB_W +: NIB_W]);
      end
   end

   assign grant_o = grant_q;
   assign hex0_o  = digit_q[0];
   assign hex1_o  = digit_q[1];
   assign hex2_o  = digit_q[2];
   assign hex3_o  = digit_q[3];
   assign hex4_o  = digit_q[4];
   assign hex5_o  = digit_q[5];
   assign hex6_o  = digit_q[6];
   assign hex7_o  = digit_q[7];

endmodule
